// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared types and constants for the gate-model BIST harness
//
// Contents: FSM state enum, pattern/response widths, LFSR/MISR feedback masks,
// and the gate-model output to response-bit mapping.

package gate_bist_pkg;

    localparam int PAT_W = 14;
    localparam int RSP_W = 10;

    // x^14 + x^5 + x^3 + x + 1 (primitive, period 16383)
    localparam logic [PAT_W-1:0] LFSR_POLY = 14'h002B;
    // x^10 + x^7 + 1
    localparam logic [RSP_W-1:0] MISR_POLY = 10'h081;

    // Gate-model output net -> rsp bit position
    localparam int RSP_BIT_N290 = 0;
    localparam int RSP_BIT_N293 = 1;
    localparam int RSP_BIT_N304 = 2;
    localparam int RSP_BIT_N305 = 3;
    localparam int RSP_BIT_N309 = 4;
    localparam int RSP_BIT_N310 = 5;
    localparam int RSP_BIT_N311 = 6;
    localparam int RSP_BIT_N312 = 7;
    localparam int RSP_BIT_N313 = 8;
    localparam int RSP_BIT_N314 = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gate_bist_galois_reg.sv
// rtl/gate_bist_galois_reg.sv - Galois shift register usable as LFSR (din=0) or MISR
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load q with load_val (takes priority over en)
//   load_val   W-bit load value
//   en         advance one Galois step, folding din into the result
//   din        W-bit parallel input (tie to 0 for a pure LFSR)
//   q          W-bit register contents

module gate_bist_galois_reg #(
    parameter int           W    = 14,
    parameter logic [W-1:0] POLY = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/gate_bist_harness.sv
// rtl/gate_bist_harness.sv - LFSR/MISR self-test wrapper around the 14-in/10-out gate model
//
// Optional macro RSP_REG_EN: register rsp_i before the MISR (adds a FLUSH cycle).
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start_i     start pulse, ignored while a run is in progress
//   seed_i      LFSR seed (0 is replaced by 1)
//   num_pat_i   number of patterns to apply
//   pat_o       pattern to gate model, bit 0 = N1 ... bit 13 = N14
//   rsp_i       gate-model response, bit order from gate_bist_pkg
//   busy_o      run in progress
//   done_o      one-cycle pulse, sig_o final
//   sig_o       MISR signature, held until the next run finishes
//   pat_idx_o   index of the pattern currently on pat_o

module gate_bist_harness #(
    parameter int               PAT_W     = gate_bist_pkg::PAT_W,
    parameter int               RSP_W     = gate_bist_pkg::RSP_W,
    parameter int               CNT_W     = 16,
    parameter logic [PAT_W-1:0] LFSR_POLY = gate_bist_pkg::LFSR_POLY,
    parameter logic [RSP_W-1:0] MISR_POLY = gate_bist_pkg::MISR_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [PAT_W-1:0] seed_i,
    input  logic [CNT_W-1:0] num_pat_i,
    output logic [PAT_W-1:0] pat_o,
    input  logic [RSP_W-1:0] rsp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [RSP_W-1:0] sig_o,
    output logic [CNT_W-1:0] pat_idx_o
);

    import gate_bist_pkg::*;

    state_t           state;
    logic [PAT_W-1:0] seed_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PAT_W-1:0] lfsr_q;
    logic [RSP_W-1:0] misr_q;
    logic [RSP_W-1:0] rsp_eff;
    logic             run_last;
    logic             misr_en;

    assign run_last  = (cnt_q == num_q - CNT_W'(1));
    assign pat_o     = lfsr_q;
    assign pat_idx_o = cnt_q;

`ifdef RSP_REG_EN
    logic [RSP_W-1:0] rsp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q <= '0;
        end else if (state == ST_RUN) begin
            rsp_q <= rsp_i;
        end
    end

    // The first RUN edge has nothing registered yet; FLUSH absorbs the last response.
    assign rsp_eff = rsp_q;
    assign misr_en = ((state == ST_RUN) && (cnt_q != '0)) || (state == ST_FLUSH);
`else
    assign rsp_eff = rsp_i;
    assign misr_en = (state == ST_RUN);
`endif

    gate_bist_galois_reg #(
        .W    (PAT_W),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_LOAD),
        .load_val (seed_q),
        .en       (state == ST_RUN),
        .din      ('0),
        .q        (lfsr_q)
    );

    gate_bist_galois_reg #(
        .W    (RSP_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_LOAD),
        .load_val ('0),
        .en       (misr_en),
        .din      (rsp_eff),
        .q        (misr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            seed_q <= '0;
            num_q  <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            sig_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        seed_q <= (seed_i == '0) ? PAT_W'(1) : seed_i;
                        num_q  <= num_pat_i;
                        busy_o <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q  <= '0;
                    busy_o <= 1'b1;
                    state  <= (num_q == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    // cnt_q stops at num-1 so pat_idx_o holds the last applied index.
                    if (run_last) begin
`ifdef RSP_REG_EN
                        state <= ST_FLUSH;
`else
                        state <= ST_DONE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    sig_o  <= misr_q;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_bist_harness.md
Name: gate_bist_harness

Overview:
- Sequential self-test stage wrapped around the 14-input / 10-output combinational gate model.
- Upstream role: a 14-bit LFSR drives the gate-model inputs N1..N14 with pseudo-random patterns.
- Downstream role: a 10-bit MISR compacts the gate-model outputs into a signature, which the simulator compares against a golden value.
- Controlled by a start/done handshake from the practical-course testbench.

Parameters:
- PAT_W, 14, pattern width (gate-model input count)
- RSP_W, 10, response width (gate-model output count)
- CNT_W, 16, width of the pattern counter
- LFSR_POLY, 14'h002B, Galois feedback mask for x^14+x^5+x^3+x+1 (primitive)
- MISR_POLY, 10'h081, Galois feedback mask for x^10+x^7+1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1
- seed_i  in  PAT_W  LFSR seed, sampled on an accepted start
- num_pat_i  in  CNT_W  number of patterns to apply, sampled on an accepted start
- pat_o  out  PAT_W  registered pattern to the gate model; pat_o[0]=N1 … pat_o[13]=N14
- rsp_i  in  RSP_W  gate-model outputs; bit order fixed in the package (N290,N293,N304,N305,N309..N314 → bits 0..9)
- busy_o  out  1  high from an accepted start until done
- done_o  out  1  one-cycle pulse when sig_o is final
- sig_o  out  RSP_W  MISR signature; held stable from done until the next accepted start
- pat_idx_o  out  CNT_W  index of the pattern currently on pat_o

Behaviour:
- Reset values: pat_o=0, sig_o=0, pat_idx_o=0, busy_o=0, done_o=0, FSM=IDLE.
- FSM states: IDLE, LOAD, RUN, FLUSH, DONE.
- IDLE: on start_i=1, go to LOAD. Latch seed and count.
  - A seed of 0 is replaced by 1, so the LFSR never locks up.
- LOAD (1 cycle):
  - lfsr←seed, misr←0, cnt←0, busy_o←1.
  - If num_pat=0, go directly to DONE with sig_o=0.
  - Otherwise go to RUN.
- RUN, one pattern per cycle:
  - pat_o=lfsr is valid for the whole cycle; the gate model is combinational, so rsp_i settles within the same cycle.
  - At the clock edge:
    - misr ← {misr[RSP_W-2:0],0} ^ (misr[RSP_W-1] ? MISR_POLY : 0) ^ rsp_eff
    - lfsr ← {lfsr[PAT_W-2:0],0} ^ (lfsr[PAT_W-1] ? LFSR_POLY : 0)
    - cnt++
  - When cnt = num_pat−1 at that edge, go to FLUSH if RSP_REG_EN is defined, else DONE.
- FLUSH (1 cycle, RSP_REG_EN only): absorb the final registered response into the MISR, then go to DONE.
- DONE (1 cycle):
  - done_o=1, busy_o=0, sig_o=misr.
  - Next state is IDLE.
  - A start_i in the DONE cycle is ignored.
- Latency (start edge to done pulse):
  - N+2 cycles without RSP_REG_EN.
  - N+3 cycles with RSP_REG_EN.
- Counter width: num_pat_i up to 2^CNT_W−1 is legal.
  - The LFSR period is 16383, so it wraps silently for larger counts.
- pat_idx_o = cnt during RUN. It holds its last value in DONE and IDLE.
- start_i during LOAD, RUN or FLUSH: ignored, no state change.
- rst asserted mid-run: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: RSP_REG_EN.
- When defined:
  - rsp_i is captured in a response register before the MISR: rsp_eff = rsp_q, which is loaded during RUN only.
  - The MISR skips its update in the first RUN cycle.
  - The FLUSH state exists, so total MISR updates still equal N.
  - Used when the gate model is too deep for single-cycle timing.
  - The signature is identical with and without the macro.
- When undefined: rsp_eff = rsp_i, there is no FLUSH state, and no response register is built.

Decomposition:
- Package gate_bist_pkg holds:
  - the FSM state enum
  - PAT_W, RSP_W, LFSR_POLY and MISR_POLY defaults
  - the rsp bit-order constant list
- One sub-module, gate_bist_galois_reg, parameterised by width and polynomial with a load/enable/data-in interface.
  - It is instantiated twice: as the LFSR with data-in=0, and as the MISR with data-in=rsp_eff.

Test Plan:
- Seed 0x0001, num_pat=15, rsp tied to 0:
  - pat_o sequence is 0x0001, 0x0002 … 0x2000, then 0x002B.
  - sig_o=0, done_o pulses once, pat_idx_o ends at 14.
- Seed 0x0000, num_pat=2: the first pattern is 0x0001 (lock-up guard), the second is 0x0002.
- num_pat=1, rsp=0x3FF → sig_o=0x3FF.
- num_pat=2, rsp=0x3FF both cycles → sig_o=0x080.
- num_pat=0 → done pulse 2 cycles after the start edge, sig_o=0, pat_o never leaves the seed value.
- start_i pulsed mid-run: ignored, and the run completes with the correct count.
- rst asserted at pattern 5 of 10 returns all outputs to 0 with no done_o; a following start runs cleanly.
- Repeat the rsp=0x3FF cases with RSP_REG_EN defined:
  - the same signatures result;
  - latency is one cycle longer.
